// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Purpose
//   Shares one single-port pixel frame-buffer RAM between VGA scan-out and a
//   host port. It sits next to the VGA timing generator and uses that block's
//   CounterX/CounterY. Scan-out always has priority. One pixel is fetched per
//   clock, one cycle ahead of the visible area, so that pixel_valid lines up
//   exactly with the display window. The host gets the RAM only in cycles
//   with no display fetch.
//
// Optional feature
//   VGA_FB_STALL_CNT_EN : when defined, adds output host_stall_cnt[15:0].
//                         This is a saturating count of the cycles in which
//                         the host was requesting but was not granted.
//
// Ports
//   clk          in   1       system / pixel clock
//   rst_n        in   1       synchronous reset, active low
//   vga_x        in   10      CounterX from the VGA timing module
//   vga_y        in   10      CounterY from the VGA timing module
//   host_req     in   1       host access request (held until host_gnt)
//   host_we      in   1       1 = write, 0 = read
//   host_addr    in   ADDR_W  host pixel address
//   host_wdata   in   PIX_W   host write data
//   host_gnt     out  1       access accepted this cycle (combinational)
//   host_rvalid  out  1       host read data valid
//   host_rdata   out  PIX_W   host read data (holds its last value)
//   mem_en       out  1       RAM enable (combinational)
//   mem_we       out  1       RAM write enable
//   mem_addr     out  ADDR_W  RAM address
//   mem_wdata    out  PIX_W   RAM write data
//   mem_rdata    in   PIX_W   RAM read data, 1 cycle after mem_en
//   pixel_valid  out  1       pixel_data valid (equals the display area)
//   pixel_data   out  PIX_W   pixel for the current CounterX/CounterY
//   host_stall_cnt out 16     (VGA_FB_STALL_CNT_EN only) host stall cycles
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int H_START  = 64,   // first visible CounterX value (must be >= 1)
  parameter int H_ACTIVE = 640,  // visible pixels per line
  parameter int V_START  = 16,   // first visible CounterY value
  parameter int V_ACTIVE = 480,  // visible lines per frame
  parameter int PIX_W    = 24,   // pixel width, LSB byte = blue
  parameter int ADDR_W   = 19    // 2**ADDR_W >= H_ACTIVE*V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        vga_x,
  input  logic [9:0]        vga_y,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [PIX_W-1:0]  host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_data
`ifdef VGA_FB_STALL_CNT_EN
  ,
  output logic [15:0]       host_stall_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Fetch window. Compare in 11 bits so that windows that reach the top of
  // the 10-bit counter range cannot overflow.
  // The window starts one pixel early because the RAM read takes one cycle.
  // ---------------------------------------------------------------------------
  localparam logic [10:0] X_FIRST = 11'(H_START - 1);
  localparam logic [10:0] X_LAST  = 11'(H_START + H_ACTIVE - 2);
  localparam logic [10:0] Y_FIRST = 11'(V_START);
  localparam logic [10:0] Y_LAST  = 11'(V_START + V_ACTIVE - 1);

  // Last linear address of the frame. The scan address stops here.
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic              x_in_window;
  logic              y_in_window;
  logic              fetch_en;
  logic              host_rd_grant;

  logic [ADDR_W-1:0] fb_addr_reg;
  logic [ADDR_W-1:0] fb_addr_next;
  logic              disp_pend_reg;
  logic              host_pend_reg;
  logic [PIX_W-1:0]  pixel_hold_reg;
  logic [PIX_W-1:0]  rdata_hold_reg;

  assign x_in_window = ({1'b0, vga_x} >= X_FIRST) && ({1'b0, vga_x} <= X_LAST);
  assign y_in_window = ({1'b0, vga_y} >= Y_FIRST) && ({1'b0, vga_y} <= Y_LAST);
  assign fetch_en    = x_in_window && y_in_window;

  // ---------------------------------------------------------------------------
  // RAM port mux. Scan-out has absolute priority. The host port sees the RAM
  // only when no fetch is needed. The mux is gated with rst_n so that every
  // output is low while reset is asserted, even inside the fetch window.
  // ---------------------------------------------------------------------------
  always_comb begin
    host_gnt      = 1'b0;
    host_rd_grant = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (rst_n) begin
      if (fetch_en) begin
        mem_en   = 1'b1;
        mem_addr = fb_addr_reg;
      end else if (host_req) begin
        host_gnt      = 1'b1;
        host_rd_grant = ~host_we;
        mem_en        = 1'b1;
        mem_we        = host_we;
        mem_addr      = host_addr;
        mem_wdata     = host_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Linear scan address. It clears on line 0 of every frame and advances by
  // one per fetch, so no x*H_ACTIVE product is needed. It stops at the last
  // frame address instead of wrapping. This means a timing source that emits
  // extra lines can never alias back onto pixel 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    fb_addr_next = fb_addr_reg;
    if (vga_y == 10'd0) begin
      fb_addr_next = '0;
    end else if (fetch_en && (fb_addr_reg != FB_LAST)) begin
      fb_addr_next = fb_addr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_addr_reg   <= '0;
      disp_pend_reg <= 1'b0;
      host_pend_reg <= 1'b0;
    end else begin
      fb_addr_reg   <= fb_addr_next;
      disp_pend_reg <= fetch_en;
      host_pend_reg <= host_rd_grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return. The pend flags are the registered valids. In the cycle
  // after an access they select the live RAM output. The result is one cycle
  // of total latency: a fetch at H_START-1 shows up at H_START. Once the
  // flag drops, the hold registers keep the last returned word on the data
  // outputs. disp_pend and host_pend can never both be set, because a cycle
  // either fetches or grants the host, never both.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_hold_reg <= '0;
      rdata_hold_reg <= '0;
    end else begin
      if (disp_pend_reg) begin
        pixel_hold_reg <= mem_rdata;
      end
      if (host_pend_reg) begin
        rdata_hold_reg <= mem_rdata;
      end
    end
  end

  // The outputs are also gated with rst_n. A read that is in flight when
  // reset asserts is therefore never reported.
  always_comb begin
    pixel_valid = 1'b0;
    pixel_data  = '0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    if (rst_n) begin
      pixel_valid = disp_pend_reg;
      pixel_data  = disp_pend_reg ? mem_rdata : pixel_hold_reg;
      host_rvalid = host_pend_reg;
      host_rdata  = host_pend_reg ? mem_rdata : rdata_hold_reg;
    end
  end

`ifdef VGA_FB_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Host stall counter. It counts the cycles in which the host waits behind
  // scan-out. It restarts at the top-left of every frame, so software can
  // read a per-frame figure.
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_reg;
  logic [15:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if ((vga_y == 10'd0) && (vga_x == 10'd0)) begin
      stall_cnt_next = '0;
    end else if (host_req && !host_gnt && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign host_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed testbench for vga_fb_arbiter. It uses a behavioural single-port
// RAM with a 1-cycle read. Expected values are worked out by hand from the
// VGA geometry. A second, small-geometry instance covers the end of the
// frame and the restart of the scan address.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vga_x;
  logic [9:0]  vga_y;
  logic        host_req;
  logic        host_we;
  logic [18:0] host_addr;
  logic [23:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [23:0] host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = 24'h0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
`ifdef VGA_FB_STALL_CNT_EN
  logic [15:0] host_stall_cnt;
  logic [15:0] s_stall_cnt;
`endif

  // Small-geometry instance: H_START=4, H_ACTIVE=8, V_START=2, V_ACTIVE=4.
  logic [9:0]  s_x;
  logic [9:0]  s_y;
  logic        s_host_gnt;
  logic        s_host_rvalid;
  logic [23:0] s_host_rdata;
  logic        s_mem_en;
  logic        s_mem_we;
  logic [4:0]  s_mem_addr;
  logic [23:0] s_mem_wdata;
  logic [23:0] s_mem_rdata = 24'h0;
  logic        s_pixel_valid;
  logic [23:0] s_pixel_data;

  logic [23:0] mem [0:(1<<19)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int early_gnt;

  always #5 clk = ~clk;

  vga_fb_arbiter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data)
`ifdef VGA_FB_STALL_CNT_EN
    ,
    .host_stall_cnt (host_stall_cnt)
`endif
  );

  vga_fb_arbiter #(
    .H_START (4),
    .H_ACTIVE(8),
    .V_START (2),
    .V_ACTIVE(4),
    .PIX_W   (24),
    .ADDR_W  (5)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (s_x),
    .vga_y       (s_y),
    .host_req    (1'b0),
    .host_we     (1'b0),
    .host_addr   (5'd0),
    .host_wdata  (24'h0),
    .host_gnt    (s_host_gnt),
    .host_rvalid (s_host_rvalid),
    .host_rdata  (s_host_rdata),
    .mem_en      (s_mem_en),
    .mem_we      (s_mem_we),
    .mem_addr    (s_mem_addr),
    .mem_wdata   (s_mem_wdata),
    .mem_rdata   (s_mem_rdata),
    .pixel_valid (s_pixel_valid),
    .pixel_data  (s_pixel_data)
`ifdef VGA_FB_STALL_CNT_EN
    ,
    .host_stall_cnt (s_stall_cnt)
`endif
  );

  // Single-port RAM, read data registered one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock and present new counters 1 ns after the edge.
  task automatic cyc(input int x, input int y);
    @(posedge clk);
    #1;
    vga_x = 10'(x);
    vga_y = 10'(y);
  endtask

  initial begin
    mem[0]   = 24'hAABBCC;
    mem[1]   = 24'h112233;
    mem[639] = 24'h123456;
    rst_n = 1'b0; vga_x = 10'd100; vga_y = 10'd20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd5; host_wdata = 24'h0;
    s_x = 10'd0; s_y = 10'd0;

    // Reset inside the display window with a host request pending.
    for (int i = 0; i < 3; i++) begin
      cyc(100, 20); #3;
      check("rst_mem_en",      32'(mem_en),      32'd0);
      check("rst_host_gnt",    32'(host_gnt),    32'd0);
      check("rst_mem_addr",    32'(mem_addr),    32'd0);
      check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      check("rst_pixel_data",  32'(pixel_data),  32'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1; vga_x = 10'd101; #3;
    check("post_rst_mem_en",   32'(mem_en),   32'd1);
    check("post_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("post_rst_host_gnt", 32'(host_gnt), 32'd0);
    cyc(102, 20); #3;
    check("post_rst_pix_valid", 32'(pixel_valid), 32'd1);
    check("post_rst_pix_data",  32'(pixel_data),  32'hAABBCC);

    // Reset while a host read is in flight: the read is discarded.
    cyc(0, 5); host_req = 1'b1; host_we = 1'b0; host_addr = 19'd0; #3;
    check("midrd_gnt", 32'(host_gnt), 32'd1);
    cyc(1, 5); rst_n = 1'b0; host_req = 1'b0; #3;
    check("midrd_rvalid_in_rst", 32'(host_rvalid), 32'd0);
    cyc(2, 5); rst_n = 1'b1; #3;
    check("midrd_rvalid_after", 32'(host_rvalid), 32'd0);

    // Scan-out of line 16 from a cleared address.
    cyc(0, 0); #3;
    cyc(62, 16); #3;
    check("x62_mem_en", 32'(mem_en), 32'd0);
    cyc(63, 16); #3;
    check("x63_mem_en",   32'(mem_en),   32'd1);
    check("x63_mem_we",   32'(mem_we),   32'd0);
    check("x63_mem_addr", 32'(mem_addr), 32'd0);
    cyc(64, 16); #3;
    check("x64_pix_valid", 32'(pixel_valid), 32'd1);
    check("x64_pix_data",  32'(pixel_data),  32'hAABBCC);
    check("x64_mem_addr",  32'(mem_addr),    32'd1);
    cyc(65, 16); #3;
    check("x65_pix_data", 32'(pixel_data), 32'h112233);
    for (int x = 66; x <= 702; x++) cyc(x, 16);
    #3;
    check("x702_mem_addr", 32'(mem_addr), 32'd639);
    cyc(703, 16); #3;
    check("x703_mem_en",    32'(mem_en),      32'd0);
    check("x703_pix_valid", 32'(pixel_valid), 32'd1);
    check("x703_pix_data",  32'(pixel_data),  32'h123456);
    cyc(704, 16); #3;
    check("x704_pix_valid", 32'(pixel_valid), 32'd0);
    check("x704_pix_hold",  32'(pixel_data),  32'h123456);
    cyc(63, 17); #3;
    check("y17_mem_addr", 32'(mem_addr), 32'd640);

    // Host writes in blanking, back to back.
    cyc(0, 5); host_req = 1'b1; host_we = 1'b1; host_addr = 19'd100; host_wdata = 24'h00FF00; #3;
    check("wr_gnt",       32'(host_gnt),  32'd1);
    check("wr_mem_we",    32'(mem_we),    32'd1);
    check("wr_mem_addr",  32'(mem_addr),  32'd100);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h00FF00);
    cyc(1, 5); host_addr = 19'd101; host_wdata = 24'h0000AA; #3;
    check("wr2_gnt",      32'(host_gnt), 32'd1);
    check("wr2_mem_addr", 32'(mem_addr), 32'd101);
    cyc(2, 5); host_req = 1'b0; #3;
    check("idle_mem_en",  32'(mem_en),      32'd0);
    check("wr_no_rvalid", 32'(host_rvalid), 32'd0);

    // Host read that stalls behind scan-out until x=703.
    cyc(0, 0); #3;
    early_gnt = 0;
    for (int x = 100; x <= 702; x++) begin
      cyc(x, 20); host_req = 1'b1; host_we = 1'b0; host_addr = 19'd100; #3;
      if (host_gnt) early_gnt++;
    end
    check("rd_early_gnts", 32'(early_gnt), 32'd0);
    cyc(703, 20); #3;
    check("rd_gnt_x703",  32'(host_gnt), 32'd1);
    check("rd_mem_addr",  32'(mem_addr), 32'd100);
    check("rd_mem_we",    32'(mem_we),   32'd0);
`ifdef VGA_FB_STALL_CNT_EN
    check("stall_cnt", 32'(host_stall_cnt), 32'd603);
`endif
    cyc(704, 20); host_addr = 19'd101; #3;
    check("rd_rvalid", 32'(host_rvalid), 32'd1);
    check("rd_rdata",  32'(host_rdata),  32'h00FF00);
    check("rd2_gnt",   32'(host_gnt),    32'd1);
    cyc(705, 20); host_req = 1'b0; #3;
    check("rd2_rvalid", 32'(host_rvalid), 32'd1);
    check("rd2_rdata",  32'(host_rdata),  32'h0000AA);
    cyc(706, 20); #3;
    check("rd_rvalid_drop", 32'(host_rvalid), 32'd0);

    // Small geometry: two full frames. Fetch window is x=3..10, y=2..5.
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 16; x++) begin
          @(posedge clk); #1; s_x = 10'(x); s_y = 10'(y); #3;
          if (y == 2 && x == 2)  check("s_pre_window_en", 32'(s_mem_en),   32'd0);
          if (y == 2 && x == 3)  check("s_first_addr",    32'(s_mem_addr), 32'd0);
          if (y == 3 && x == 3)  check("s_line1_addr",    32'(s_mem_addr), 32'd8);
          if (y == 5 && x == 10) check("s_last_addr",     32'(s_mem_addr), 32'd31);
          if (y == 5 && x == 11) check("s_post_window_en", 32'(s_mem_en),  32'd0);
          if (y == 6 && x == 10) check("s_below_frame_en", 32'(s_mem_en),  32'd0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
